uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//   Receive-side byte buffer sitting directly downstream of the UART receiver.
//   Captures each byte qualified by the receiver's one-cycle data-available strobe.
//   Presents bytes to the consumer (CPU/command logic) over a valid/ready interface.
//   Flags overruns when the consumer falls behind.
// PARAMETERS
//   DEPTH        16   entries; power of two, >= 2
//   AFULL_LEVEL  12   o_almost_full asserts when count >= AFULL_LEVEL; 1..DEPTH
// PORTS
//   clk            in   1   single system clock, all logic on posedge
//   rst            in   1   synchronous, active-high reset
//   i_data_avail   in   1   one-cycle strobe from receiver: byte valid
//   i_data_byte    in   8   received byte, sampled when i_data_avail=1
//   o_valid        out  1   head entry available
//   o_data         out  8   head entry; stable while o_valid && !i_ready
//   i_ready        in   1   consumer accepts head; pop when o_valid && i_ready
//   o_count        out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
//   o_full         out  1   count == DEPTH
//   o_almost_full  out  1   count >= AFULL_LEVEL
//   o_overrun      out  1   sticky: a byte was dropped because FIFO was full
//   i_clr_overrun  in   1   one-cycle pulse clears o_overrun
// BEHAVIOUR
//   - Reset: wr_ptr=rd_ptr=0, count=0, o_valid=0, o_full=0, o_almost_full=0,
//     o_overrun=0; o_data don't-care; RAM contents not cleared (unreachable).
//   - Reset mid-operation discards all stored bytes; a strobe coincident with rst ignored.
//   - push = i_data_avail && (!full || pop); pop = o_valid && i_ready.
//   - Latency: byte strobed in cycle N appears on o_valid/o_data at cycle N+1 if empty.
//   - First-word-fall-through: o_data = mem[rd_ptr], asynchronous read of RAM.
//   - Pointers are log2(DEPTH) bits and wrap modulo DEPTH; count tracked separately.
//   - push && !pop: count+1; pop && !push: count-1; both: count unchanged.
//   - Full and push with same-cycle pop: byte accepted, no overrun.
//   - Full and push without pop: byte dropped, pointers unchanged, o_overrun <= 1.
//   - Empty: i_ready ignored; no underflow, pointers unchanged.
//   - i_clr_overrun and new overrun in same cycle: set wins (o_overrun stays 1).
//   - All status outputs registered or derived from registered count, no comb path
//     from i_data_avail to outputs.
//   - Control FSM: EMPTY -> (push) NONEMPTY -> (count reaches DEPTH) FULL;
//     FULL -> (pop without push) NONEMPTY -> (last pop) EMPTY; rst -> EMPTY.
// CONFIGURATION
//   UART_RX_FIFO_STATS_EN defined: adds outputs o_rx_total[15:0] (bytes accepted) and
//     o_drop_total[15:0] (bytes dropped); both saturate at 16'hFFFF, reset to 0,
//     cleared by rst only.
//   Undefined: those ports and counters do not exist; all other behaviour identical.
// STRUCTURE
//   - Shared package uart_pkg: UART_BYTE_W=8, typedef uart_byte_t, FIFO state encoding
//     (EMPTY/NONEMPTY/FULL); uart_pkg shared with receiver/transmitter.
//   - One sub-module: uart_fifo_mem (DEPTH x 8 RAM, sync write, async read).
//   - Top holds pointers, count, FSM, flags, optional stats counters.
// TESTING
//   1. rst, then strobe 0x5A once -> next cycle o_valid=1, o_data=0x5A, o_count=1.
//   2. Push 16 bytes 0x00..0x0F with i_ready=0 -> o_full=1, o_almost_full from 12th;
//      drain -> 0x00..0x0F in order, o_valid=0 after last.
//   3. Full, strobe 0xEE, no pop -> byte lost, o_overrun=1, count 16;
//      pulse i_clr_overrun -> o_overrun=0.
//   4. Full, strobe 0x77 with same-cycle pop -> no overrun, count 16, 0x77 read last.
//   5. Fill 5 bytes, assert rst for one cycle -> o_valid=0, o_count=0; next strobe 0x33
//      appears as head.
//   6. STATS_EN: 20 strobes into empty FIFO with i_ready=0 ->
//      o_rx_total=16, o_drop_total=4.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver, the transmitter and the
// receive FIFO.
//   UART_BYTE_W   width of one UART character
//   uart_byte_t   one UART character
//   fifo_state_e  occupancy state of the receive FIFO control FSM
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    typedef logic [UART_BYTE_W-1:0] uart_byte_t;

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_NONEMPTY = 2'd1,
        ST_FULL     = 2'd2
    } fifo_state_e;

endpackage : uart_pkg

// File: rtl/uart_fifo_mem.sv
// Storage array for the UART receive FIFO.
// The write is synchronous and the read is asynchronous, so the entry at the
// head pointer can be presented to the consumer in the same cycle.
// Contents are not reset; an entry is only read after it has been written.
// Ports:
//   clk        system clock
//   wr_en_i    write strobe
//   wr_addr_i  write address
//   wr_data_i  write data
//   rd_addr_i  read address
//   rd_data_o  read data, combinational from rd_addr_i
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  uart_byte_t    wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output uart_byte_t    rd_data_o
);

    uart_byte_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule : uart_fifo_mem

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO that sits behind the UART receiver.
// It captures each byte marked by the receiver's one-cycle strobe, presents the
// bytes first-word-fall-through on a valid/ready interface, and keeps a sticky
// overrun flag for bytes dropped while the FIFO was full.
// Optional build macro: UART_RX_FIFO_STATS_EN adds the saturating counters
// o_rx_total and o_drop_total.
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset
//   i_data_avail   receiver strobe, byte valid
//   i_data_byte    received byte
//   o_valid        head entry available
//   o_data         head entry
//   i_ready        consumer accepts the head entry
//   o_count        occupancy, 0..DEPTH
//   o_full         occupancy == DEPTH
//   o_almost_full  occupancy >= AFULL_LEVEL
//   o_overrun      sticky dropped-byte flag
//   i_clr_overrun  clears o_overrun
//   o_rx_total     bytes accepted   (UART_RX_FIFO_STATS_EN only)
//   o_drop_total   bytes dropped    (UART_RX_FIFO_STATS_EN only)
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int AFULL_LEVEL = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_data_avail,
    input  uart_byte_t             i_data_byte,
    output logic                   o_valid,
    output uart_byte_t             o_data,
    input  logic                   i_ready,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_almost_full,
    output logic                   o_overrun,
    input  logic                   i_clr_overrun
`ifdef UART_RX_FIFO_STATS_EN
    ,
    output logic [15:0]            o_rx_total,
    output logic [15:0]            o_drop_total
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fifo_state_e      state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             afull_q, afull_d;
    logic             overrun_q, overrun_d;
    logic             push, pop, drop;

    // Handshake decode. Status comes from registered state only, so there is
    // no combinational path from i_data_avail to any output.
    always_comb begin
        pop  = (state_q != ST_EMPTY) && i_ready;
        push = i_data_avail && ((state_q != ST_FULL) || pop);
        drop = i_data_avail && (state_q == ST_FULL) && !pop;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        afull_d = (count_d >= CNT_W'(AFULL_LEVEL));
        // A new drop outranks a clear in the same cycle.
        if (drop) begin
            overrun_d = 1'b1;
        end else if (i_clr_overrun) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // Control FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    state_d = ST_NONEMPTY;
                end
            end
            ST_NONEMPTY: begin
                if (count_d == CNT_W'(DEPTH)) begin
                    state_d = ST_FULL;
                end else if (count_d == '0) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop && !push) begin
                    state_d = ST_NONEMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            afull_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            afull_q   <= afull_d;
            overrun_q <= overrun_d;
        end
    end

    uart_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (push && !rst),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (i_data_byte),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (o_data)
    );

    assign o_valid       = (state_q != ST_EMPTY);
    assign o_full        = (state_q == ST_FULL);
    assign o_count       = count_q;
    assign o_almost_full = afull_q;
    assign o_overrun     = overrun_q;

`ifdef UART_RX_FIFO_STATS_EN
    logic [15:0] rx_total_q, drop_total_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_total_q   <= '0;
            drop_total_q <= '0;
        end else begin
            if (push && (rx_total_q != 16'hFFFF)) begin
                rx_total_q <= rx_total_q + 16'd1;
            end
            if (drop && (drop_total_q != 16'hFFFF)) begin
                drop_total_q <= drop_total_q + 16'd1;
            end
        end
    end

    assign o_rx_total   = rx_total_q;
    assign o_drop_total = drop_total_q;
`endif

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo. Accepted bytes are queued as expected
// data; a monitor compares every byte the consumer takes against that queue.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_data_avail = 1'b0;
    logic [7:0] i_data_byte = 8'h00;
    logic       o_valid;
    logic [7:0] o_data;
    logic       i_ready = 1'b0;
    logic [4:0] o_count;
    logic       o_full;
    logic       o_almost_full;
    logic       o_overrun;
    logic       i_clr_overrun = 1'b0;
`ifdef UART_RX_FIFO_STATS_EN
    logic [15:0] o_rx_total;
    logic [15:0] o_drop_total;
`endif

    int errors = 0;
    int checks = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH(16), .AFULL_LEVEL(12)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_data_avail  (i_data_avail),
        .i_data_byte   (i_data_byte),
        .o_valid       (o_valid),
        .o_data        (o_data),
        .i_ready       (i_ready),
        .o_count       (o_count),
        .o_full        (o_full),
        .o_almost_full (o_almost_full),
        .o_overrun     (o_overrun),
        .i_clr_overrun (i_clr_overrun)
`ifdef UART_RX_FIFO_STATS_EN
        ,
        .o_rx_total    (o_rx_total),
        .o_drop_total  (o_drop_total)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted head entry must match the oldest expected byte.
    always @(negedge clk) begin
        if (!rst && o_valid && i_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pop_data: got %0h expected nothing (queue empty)", o_data);
            end else begin
                logic [7:0] exp_b;
                exp_b = sb.pop_front();
                if (o_data !== exp_b) begin
                    errors++;
                    $display("FAIL pop_data: got %0h expected %0h", o_data, exp_b);
                end
            end
        end
    end

    // One strobe; the byte is queued as expected only if it should be kept.
    task automatic strobe(input logic [7:0] b, input bit keep);
        i_data_avail = 1'b1;
        i_data_byte  = b;
        if (keep) sb.push_back(b);
        @(posedge clk);
        #1;
        i_data_avail = 1'b0;
    endtask

    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        i_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (!o_valid) begin
                done = 1'b1;
                break;
            end
        end
        i_ready = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got o_valid=1 expected 0 within 40 cycles", name);
        end
        chk({name, "_valid"}, o_valid, 0);
        chk({name, "_count"}, o_count, 0);
        chk({name, "_sb_left"}, sb.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_valid", o_valid, 0);
        chk("rst_count", o_count, 0);
        chk("rst_full", o_full, 0);
        chk("rst_afull", o_almost_full, 0);
        chk("rst_overrun", o_overrun, 0);
`ifdef UART_RX_FIFO_STATS_EN
        chk("rst_rx_total", o_rx_total, 0);
        chk("rst_drop_total", o_drop_total, 0);
`endif

        // 1: single byte, visible the cycle after the strobe
        strobe(8'h5A, 1'b1);
        chk("t1_valid", o_valid, 1);
        chk("t1_data", o_data, 8'h5A);
        chk("t1_count", o_count, 1);
        drain("t1_drain");

        // Empty FIFO ignores i_ready
        i_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        i_ready = 1'b0;
        chk("empty_ready_count", o_count, 0);
        chk("empty_ready_valid", o_valid, 0);

        // 2: fill 0x00..0x0F, watch thresholds
        for (int k = 1; k <= 16; k++) begin
            strobe(8'(k - 1), 1'b1);
            chk("t2_count", o_count, k);
            chk("t2_afull", o_almost_full, (k >= 12) ? 1 : 0);
            chk("t2_full", o_full, (k == 16) ? 1 : 0);
        end
        chk("t2_head", o_data, 8'h00);
        drain("t2_drain");

        // 3: overrun when full, clear, set-wins-over-clear
        for (int k = 0; k < 16; k++) strobe(8'h10 + 8'(k), 1'b1);
        strobe(8'hEE, 1'b0);
        chk("t3_overrun", o_overrun, 1);
        chk("t3_count", o_count, 16);
        chk("t3_head", o_data, 8'h10);
        i_clr_overrun = 1'b1;
        @(posedge clk);
        #1;
        i_clr_overrun = 1'b0;
        chk("t3_clr", o_overrun, 0);
        i_clr_overrun = 1'b1;
        strobe(8'hEF, 1'b0);
        i_clr_overrun = 1'b0;
        chk("t3_set_wins", o_overrun, 1);
        i_clr_overrun = 1'b1;
        @(posedge clk);
        #1;
        i_clr_overrun = 1'b0;
        chk("t3_clr2", o_overrun, 0);

        // 4: push while full with same-cycle pop
        i_ready = 1'b1;
        strobe(8'h77, 1'b1);
        i_ready = 1'b0;
        chk("t4_overrun", o_overrun, 0);
        chk("t4_count", o_count, 16);
        chk("t4_full", o_full, 1);
        chk("t4_head", o_data, 8'h11);
        drain("t4_drain");

        // 5: reset mid-operation, strobe during reset ignored
        for (int k = 0; k < 5; k++) strobe(8'hA0 + 8'(k), 1'b1);
        chk("t5_count_pre", o_count, 5);
        i_data_avail = 1'b1;
        i_data_byte  = 8'h99;
        do_reset();
        i_data_avail = 1'b0;
        chk("t5_valid", o_valid, 0);
        chk("t5_count", o_count, 0);
        strobe(8'h33, 1'b1);
        chk("t5_head", o_data, 8'h33);
        chk("t5_count1", o_count, 1);
        drain("t5_drain");

        // 6: 20 strobes into an empty FIFO, consumer stalled
        do_reset();
        for (int k = 0; k < 20; k++) strobe(8'hC0 + 8'(k), (k < 16) ? 1'b1 : 1'b0);
        chk("t6_count", o_count, 16);
        chk("t6_overrun", o_overrun, 1);
`ifdef UART_RX_FIFO_STATS_EN
        chk("t6_rx_total", o_rx_total, 16);
        chk("t6_drop_total", o_drop_total, 4);
`endif
        drain("t6_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule : tb_uart_rx_fifo
